// File: rtl/simon_pkg.sv
// Shared Simon32/64 definitions: word width, round count, z0 sequence,
// the round function f and the key-schedule word generator.
package simon_pkg;

  localparam int W      = 16;
  localparam int ROUNDS = 32;

  // z0 sequence; bit j of the sequence is the j-th character from the left.
  localparam logic [61:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  function automatic logic z0_bit(input logic [5:0] j);
    logic [5:0] idx;
    idx = 6'd61 - j;
    return Z0[idx];
  endfunction

  // f(v) = (v<<<1 & v<<<8) ^ (v<<<2); shared with the encrypt round.
  function automatic logic [W-1:0] f(input logic [W-1:0] v);
    return ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
  endfunction

  // k[i] from k[i-1], k[i-3], k[i-4] for a 4-word master key; j = i-4.
  function automatic logic [W-1:0] key_word(input logic [W-1:0] km1,
                                             input logic [W-1:0] km3,
                                             input logic [W-1:0] km4,
                                             input logic [5:0]   j);
    logic [W-1:0] t;
    t = {km1[2:0], km1[15:3]} ^ km3;
    return ~km4 ^ t ^ {t[0], t[15:1]} ^ {15'd0, z0_bit(j)} ^ 16'h0003;
  endfunction

endpackage

// File: rtl/simon_dec_round.sv
// One combinational Simon32 decryption round: (x,y) -> (y, x ^ f(y) ^ k).
module simon_dec_round (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] k,
  output logic [15:0] x_n,
  output logic [15:0] y_n
);
  import simon_pkg::*;

  assign x_n = y;
  assign y_n = x ^ f(y) ^ k;

endmodule

// File: rtl/simon_dec.sv
// Iterative Simon32/64 decryptor: expands the key schedule into a 32-word
// store (skippable when the stored schedule is reused), then runs one
// round per clock with round keys k31 down to k0.
module simon_dec #(
  parameter int ROUNDS    = 32,
  parameter int KEY_WORDS = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] key,
  input  logic        key_new,
  input  logic [31:0] cipher_text,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] plain_text,
  output logic        out_valid,
  input  logic        out_ready
);
  import simon_pkg::*;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_ROUND  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [4:0] LAST = 5'(ROUNDS - 1);

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  rnd_q, rnd_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [31:0] pt_q, pt_d;
  logic        ov_q, ov_d;
  logic        key_ok_q, key_ok_d;

  // Round-key store; intentionally not reset (key_ok guards its contents).
  logic [15:0] ks_q [0:ROUNDS-1];
  logic        ld_key, exp_we;
  logic [4:0]  exp_j;
  logic [15:0] exp_k;
  logic [15:0] rx, ry;

  assign exp_j = cnt_q - 5'd4;
  assign exp_k = key_word(ks_q[cnt_q - 5'd1], ks_q[cnt_q - 5'd3],
                          ks_q[cnt_q - 5'd4], {1'b0, exp_j});

  simon_dec_round u_round (
    .x   (x_q),
    .y   (y_q),
    .k   (ks_q[rnd_q]),
    .x_n (rx),
    .y_n (ry)
  );

  assign in_ready   = (state_q == S_IDLE);
  assign plain_text = pt_q;
  assign out_valid  = ov_q;

  // Next-state / datapath control for the IDLE-EXPAND-ROUND-DONE sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rnd_d    = rnd_q;
    x_d      = x_q;
    y_d      = y_q;
    pt_d     = pt_q;
    ov_d     = ov_q;
    key_ok_d = key_ok_q;
    ld_key   = 1'b0;
    exp_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d      = cipher_text[31:16];
          y_d      = cipher_text[15:0];
          key_ok_d = 1'b1;
          if (key_new || !key_ok_q) begin
            // Master key words are loaded only when a fresh expansion runs,
            // so a reuse request keeps the previous schedule intact.
            ld_key  = 1'b1;
            cnt_d   = 5'(KEY_WORDS);
            state_d = S_EXPAND;
          end else begin
            rnd_d   = LAST;
            state_d = S_ROUND;
          end
        end
      end
      S_EXPAND: begin
        exp_we = 1'b1;
        if (cnt_q == LAST) begin
          rnd_d   = LAST;
          state_d = S_ROUND;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_ROUND: begin
        x_d = rx;
        y_d = ry;
        if (rnd_q == 5'd0) begin
          pt_d    = {rx, ry};
          ov_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          rnd_d = rnd_q - 5'd1;
        end
      end
      default: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Control and data registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      rnd_q    <= 5'd0;
      x_q      <= 16'd0;
      y_q      <= 16'd0;
      pt_q     <= 32'd0;
      ov_q     <= 1'b0;
      key_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rnd_q    <= rnd_d;
      x_q      <= x_d;
      y_q      <= y_d;
      pt_q     <= pt_d;
      ov_q     <= ov_d;
      key_ok_q <= key_ok_d;
    end
  end

  // Round-key store writes: master key on acceptance, one word per EXPAND.
  always_ff @(posedge clk) begin
    if (ld_key) begin
      ks_q[0] <= key[15:0];
      ks_q[1] <= key[31:16];
      ks_q[2] <= key[47:32];
      ks_q[3] <= key[63:48];
    end else if (exp_we) begin
      ks_q[cnt_q] <= exp_k;
    end
  end

endmodule

// File: tb/tb_simon_dec.sv
// Directed bench for simon_dec: known-answer, schedule reuse, backpressure,
// reset mid-round, continuous in_valid and encrypt/decrypt round trips.
module tb_simon_dec;

  localparam logic [61:0] Z0_SEQ =
    62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
  localparam logic [31:0] KAT_CT  = 32'hc69be9bb;
  localparam logic [31:0] KAT_PT  = 32'h65656877;

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] key;
  logic        key_new;
  logic [31:0] cipher_text;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] plain_text;
  logic        out_valid;
  logic        out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  simon_dec #(.ROUNDS(32), .KEY_WORDS(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .key         (key),
    .key_new     (key_new),
    .cipher_text (cipher_text),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .plain_text  (plain_text),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rol(input logic [15:0] v, input int s);
    return 16'((v << s) | (v >> (16 - s)));
  endfunction

  function automatic logic [15:0] ror(input logic [15:0] v, input int s);
    return 16'((v >> s) | (v << (16 - s)));
  endfunction

  // Reference 32-round Simon32/64 encryptor.
  function automatic logic [31:0] encrypt(input logic [63:0] k64, input logic [31:0] p);
    logic [15:0] k [32];
    logic [15:0] t, x, y, tmp;
    for (int i = 0; i < 4; i++) k[i] = k64[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t    = ror(k[i-1], 3) ^ k[i-3];
      k[i] = ~k[i-4] ^ t ^ ror(t, 1) ^ {15'd0, Z0_SEQ[61-(i-4)]} ^ 16'h0003;
    end
    x = p[31:16];
    y = p[15:0];
    for (int i = 0; i < 32; i++) begin
      tmp = x;
      x   = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ k[i];
      y   = tmp;
    end
    return {x, y};
  endfunction

  // Issue one request, scramble inputs afterwards, count edges to out_valid.
  task automatic run_req(input logic [63:0] k, input logic kn, input logic [31:0] ct,
                         output logic [31:0] pt, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("idle_wait", 64'(in_ready), 64'd1);
    key = k; key_new = kn; cipher_text = ct; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; key = ~k; key_new = ~kn; cipher_text = ~ct;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
    end
    if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
    pt = plain_text;
  endtask

  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pt, rp, rk_pt;
    logic [63:0] rk;
    int lat, acc, outs;

    rstn = 1'b0; key = '0; key_new = 1'b0; cipher_text = '0;
    in_valid = 1'b0; out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_plain",     64'(plain_text), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    chk("model_kat", 64'(encrypt(KAT_KEY, KAT_PT)), 64'(KAT_CT));

    // Known answer with expansion
    run_req(KAT_KEY, 1'b1, KAT_CT, pt, lat);
    chk("kat_lat",   64'(lat), 64'd60);
    chk("kat_plain", 64'(pt),  64'(KAT_PT));

    // Backpressure: DONE holds for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid),  64'd1);
      chk("bp_plain",     64'(plain_text), 64'(KAT_PT));
      chk("bp_in_ready",  64'(in_ready),   64'd0);
    end
    pop();
    chk("pop_in_ready",  64'(in_ready),  64'd1);
    chk("pop_out_valid", 64'(out_valid), 64'd0);

    // Schedule reuse
    run_req(KAT_KEY, 1'b0, KAT_CT, pt, lat);
    chk("reuse_lat",   64'(lat), 64'd32);
    chk("reuse_plain", 64'(pt),  64'(KAT_PT));
    pop();

    // Reset at edge 40 (mid-ROUND), then reuse request must re-expand
    @(negedge clk);
    key = KAT_KEY; key_new = 1'b1; cipher_text = KAT_CT; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (39) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_in_ready",  64'(in_ready),   64'd1);
    chk("mid_rst_out_valid", 64'(out_valid),  64'd0);
    chk("mid_rst_plain",     64'(plain_text), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("mid_rst_release_ready", 64'(in_ready), 64'd1);
    run_req(KAT_KEY, 1'b0, KAT_CT, pt, lat);
    chk("forced_exp_lat",   64'(lat), 64'd60);
    chk("forced_exp_plain", 64'(pt),  64'(KAT_PT));
    pop();

    // in_valid held high: one acceptance per IDLE visit, period 34 edges
    @(negedge clk);
    key = KAT_KEY; key_new = 1'b0; cipher_text = KAT_CT;
    in_valid = 1'b1; out_ready = 1'b1;
    acc = 0; outs = 0;
    for (int i = 0; i < 340; i++) begin
      if (in_ready) acc++;
      if (out_valid) begin
        outs++;
        chk("stream_plain", 64'(plain_text), 64'(KAT_PT));
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stream_accepts", 64'(acc),  64'd10);
    chk("stream_outputs", 64'(outs), 64'd10);
    chk("stream_end_idle", 64'(in_ready), 64'd1);

    // Round trips against the reference encryptor; every 4th reuses the key
    rk = KAT_KEY;
    for (int i = 0; i < 1000; i++) begin
      if (i % 4 != 3) rk = {$urandom, $urandom};
      rk_pt = $urandom;
      run_req(rk, (i % 4 != 3), encrypt(rk, rk_pt), rp, lat);
      chk("rt_plain", 64'(rp), 64'(rk_pt));
      chk("rt_lat", 64'(lat), (i % 4 != 3) ? 64'd60 : 64'd32);
      pop();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
